fifo_wr_arbiter: RTL and testbench

//  Round-robin, burst-holding arbiter that shares the async FIFO write port

---
 rtl/fifo_wr_arbiter_if.sv | 17 +
 rtl/fifo_wr_arbiter.sv | 53 +++++
 tb/tb_fifo_wr_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester bundle plus FIFO write port shared through the arbiter
interface fifo_wr_arbiter_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
);
    localparam int IW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       gnt;
    logic [IW-1:0]            owner;
    logic                     busy;
    logic                     winc;
    logic [WIDTH-1:0]         wdata;
    logic                     wfull;
    modport master (input req, req_data, wfull, output gnt, owner, busy, winc, wdata);
    modport slave (output req, req_data, wfull, input gnt, owner, busy, winc, wdata);
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst-holding arbiter driving an async FIFO write port
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input logic               wclk,
    input logic               wrst,
    fifo_wr_arbiter_if.master bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    typedef enum logic {ARB, BURST} state_t;
    state_t          state;
    logic [IW-1:0]   owner, rr_ptr, sel, nxt;
    logic [BW-1:0]   beat_cnt;
    logic            own_req, beat, last;
    // descending scan so the requester closest to rr_ptr is written last and wins
    always_comb begin
        sel = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (bus.req[IW'((int'(rr_ptr) + k) % NUM_REQ)]) sel = IW'((int'(rr_ptr) + k) % NUM_REQ);
    end
    assign own_req    = bus.req[owner];
    assign beat       = state == BURST && own_req && !bus.wfull && !wrst;
    assign last       = beat_cnt == BW'(MAX_BURST - 1);
    assign nxt        = owner == IW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
    assign bus.winc   = beat;
    assign bus.gnt    = beat ? NUM_REQ'(1) << owner : '0;
    assign bus.wdata  = (state == BURST && !wrst) ? bus.req_data[owner*WIDTH +: WIDTH] : '0;
    assign bus.busy   = state == BURST && !wrst;
    assign bus.owner  = owner;
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state    <= ARB;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else if (state == ARB) begin
            if (|bus.req) begin
                state    <= BURST;
                owner    <= sel;
                beat_cnt <= '0;
            end
        end else if (!own_req || (beat && last)) begin
            state    <= ARB;
            rr_ptr   <= nxt;
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed requester stimulus with a write scoreboard checked by a monitor
module tb_fifo_wr_arbiter;
    logic wclk = 1'b0;
    logic wrst = 1'b1;
    always #5 wclk = ~wclk;
    fifo_wr_arbiter_if #(.WIDTH(8), .NUM_REQ(4)) bus ();
    fifo_wr_arbiter #(.WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut (.wclk(wclk), .wrst(wrst), .bus(bus.master));
    logic [7:0]  src [4][$];
    logic [3:0]  en;
    logic [11:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int wr_cnt [4];
    int wr_total = 0;
    int cyc = 0;
    // monitor: every FIFO write must match the head of the expected queue
    always @(negedge wclk) begin
        if (bus.winc) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got gnt=%b data=%h expected no write", bus.gnt, bus.wdata);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({bus.gnt, bus.wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got gnt=%b data=%h expected gnt=%b data=%h", bus.gnt, bus.wdata, e[11:8], e[7:0]);
                end
            end
            wr_total++;
            for (int i = 0; i < 4; i++) if (bus.gnt[i]) wr_cnt[i]++;
        end else if (bus.gnt !== 4'b0000) begin
            checks++;
            errors++;
            $display("FAIL gnt_without_winc: got gnt=%b expected 0000", bus.gnt);
        end
    end
    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask
    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            bus.req[i] = en[i] && src[i].size() > 0;
            bus.req_data[i*8 +: 8] = src[i].size() > 0 ? src[i][0] : 8'h00;
        end
    endtask
    task automatic step();
        logic [3:0] g;
        @(negedge wclk);
        g = bus.gnt;
        @(posedge wclk);
        #1;
        for (int i = 0; i < 4; i++) if (g[i] && src[i].size() > 0) void'(src[i].pop_front());
        drive();
        cyc++;
    endtask
    function automatic bit pending();
        pending = 1'b0;
        for (int i = 0; i < 4; i++) if (en[i] && src[i].size() > 0) pending = 1'b1;
    endfunction
    task automatic run_drain(input string name, input int bound, output int n);
        n = 0;
        while (pending() && n < bound) begin
            step();
            n++;
        end
        chk(name, int'(n < bound), 1);
    endtask
    task automatic load(input int i, input logic [7:0] first, input int n);
        for (int k = 0; k < n; k++) src[i].push_back(first + 8'(k));
        en[i] = 1'b1;
    endtask
    task automatic push_exp(input int o, input logic [7:0] d);
        exp_q.push_back({4'(1 << o), d});
    endtask
    task automatic reset_all();
        wrst = 1'b1;
        bus.wfull = 1'b0;
        en = '0;
        for (int i = 0; i < 4; i++) src[i].delete();
        drive();
        step();
        step();
        chk("sb_empty", exp_q.size(), 0);
        wrst = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        int n, c0, w0, w3;
        bus.req = '0;
        bus.req_data = '0;
        bus.wfull = 1'b0;
        en = '0;
        for (int i = 0; i < 4; i++) wr_cnt[i] = 0;
        // reset with every requester active
        for (int i = 0; i < 4; i++) load(i, 8'hA0, 4);
        drive();
        repeat (2) begin
            step();
            chk("rst_winc", bus.winc, 0);
            chk("rst_gnt", bus.gnt, 0);
            chk("rst_busy", bus.busy, 0);
        end
        wrst = 1'b0;
        step();
        chk("rst_first_busy", bus.busy, 1);
        chk("rst_first_owner", bus.owner, 0);
        wrst = 1'b1;
        #1;
        chk("rst_force_winc", bus.winc, 0);
        reset_all();
        // solo requester 1, eight beats in two bursts
        load(1, 8'h11, 8);
        drive();
        for (int k = 0; k < 8; k++) push_exp(1, 8'h11 + 8'(k));
        c0 = cyc;
        run_drain("solo_drain", 30, n);
        chk("solo_cycles", cyc - c0, 10);
        reset_all();
        // all requesters busy: 0,1,2,3,0 with one bubble between bursts
        for (int i = 0; i < 4; i++) load(i, 8'((i + 2) * 16), 8);
        drive();
        for (int b = 0; b < 5; b++)
            for (int k = 0; k < 4; k++) push_exp(b % 4, 8'(((b % 4) + 2) * 16 + (b == 4 ? 4 : 0) + k));
        w0 = wr_total;
        repeat (25) step();
        chk("all_writes", wr_total - w0, 20);
        chk("all_end_busy", bus.busy, 0);
        reset_all();
        // stall owner 2 after two beats
        load(2, 8'h40, 4);
        load(3, 8'h50, 4);
        drive();
        for (int k = 0; k < 4; k++) push_exp(2, 8'h40 + 8'(k));
        for (int k = 0; k < 4; k++) push_exp(3, 8'h50 + 8'(k));
        repeat (3) step();
        bus.wfull = 1'b1;
        #1;
        chk("stall_winc", bus.winc, 0);
        chk("stall_gnt", bus.gnt, 0);
        repeat (3) begin
            step();
            chk("stall_owner", bus.owner, 2);
            chk("stall_beat_cnt", dut.beat_cnt, 2);
            chk("stall_busy", bus.busy, 1);
        end
        bus.wfull = 1'b0;
        run_drain("stall_drain", 30, n);
        reset_all();
        // owner 1 drops after two beats; rotation resumes at 2
        load(1, 8'h61, 2);
        load(2, 8'h70, 4);
        load(3, 8'h80, 4);
        drive();
        for (int k = 0; k < 2; k++) push_exp(1, 8'h61 + 8'(k));
        for (int k = 0; k < 4; k++) push_exp(2, 8'h70 + 8'(k));
        for (int k = 0; k < 4; k++) push_exp(3, 8'h80 + 8'(k));
        repeat (3) step();
        chk("drop_owner1", bus.owner, 1);
        repeat (2) step();
        chk("drop_next_owner", bus.owner, 2);
        run_drain("drop_drain", 30, n);
        reset_all();
        // reset in the middle of owner 3's burst
        w3 = wr_cnt[3];
        load(3, 8'h90, 4);
        drive();
        push_exp(3, 8'h90);
        push_exp(3, 8'h91);
        repeat (3) step();
        wrst = 1'b1;
        #1;
        chk("midrst_winc", bus.winc, 0);
        chk("midrst_gnt", bus.gnt, 0);
        step();
        wrst = 1'b0;
        load(0, 8'hB0, 4);
        drive();
        chk("midrst_req", bus.req, 4'b1001);
        for (int k = 0; k < 4; k++) push_exp(0, 8'hB0 + 8'(k));
        step();
        chk("midrst_owner", bus.owner, 0);
        chk("midrst_busy", bus.busy, 1);
        repeat (4) step();
        chk("midrst_owner3_writes", wr_cnt[3] - w3, 2);
        reset_all();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
